obs_overlap_accum: RTL

- Sequential, parametrised successor to the OBS level-4 overlap recombination stage.
- Collects the four even/odd sub-products (EE, EO, OE, OO) of a split GF(2) polynomial multiplication one per beat from a single shared sub-multiplier, in any order.
- XOR-accumulates each beat into its interleaved position and emits the recombined 2W+1-bit product over a valid/ready handshake.
- Sits between the time-multiplexed sub-multiplier and the next-level overlap/reduction stage.

---
 rtl/obs_overlap_accum_if.sv | 28 ++
 rtl/obs_overlap_accum.sv | 115 +++++++++++
 2 files changed

// File: rtl/obs_overlap_accum_if.sv
// Handshake and status bundle between the shared sub-multiplier, the
// overlap accumulator and the downstream overlap/reduction stage.
interface obs_overlap_accum_if #(
    parameter int unsigned W = 25
);
    logic           abort;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_sel;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [2*W:0]   out_data;
    logic [3:0]     beat_mask;
    logic           err_dup;

    // Producer/consumer side (sub-multiplier feed and downstream sink)
    modport master (
        output abort, in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, beat_mask, err_dup
    );

    // Accumulator side
    modport slave (
        input  abort, in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, beat_mask, err_dup
    );
endinterface

// File: rtl/obs_overlap_accum.sv
// Overlap recombination: XOR-collects the EE/EO/OE/OO sub-products of a split
// GF(2) multiply (one beat each, any order) into the interleaved 2W+1-bit
// product and offers it downstream over valid/ready.
module obs_overlap_accum #(
    parameter int unsigned W = 25
) (
    input  logic                  clk,
    input  logic                  rst,
    obs_overlap_accum_if.slave    bus
);
    localparam int unsigned OW = 2 * W + 1;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [OW-1:0]   acc_q, acc_d;
    logic [OW-1:0]   out_data_q, out_data_d;
    logic [3:0]      mask_q, mask_d;
    logic            out_valid_q, out_valid_d;
    logic            err_dup_q, err_dup_d;

    logic            in_ready_c;
    logic            accept_c;
    logic [3:0]      sel_bit_c;
    logic [OW-1:0]   mapped_c;

    // Ready only while collecting, not aborting, and out of reset
    always_comb begin
        in_ready_c = !rst && (state_q == S_COLLECT) && !bus.abort;
        accept_c   = bus.in_valid && in_ready_c;
        sel_bit_c  = 4'(4'b0001 << bus.in_sel);
    end

    // Place the beat's coefficients at their interleaved positions
    always_comb begin
        mapped_c = '0;
        for (int unsigned k = 0; k < W; k++) begin
            unique case (bus.in_sel)
                2'd0:    mapped_c[2*k]   = bus.in_data[k];
                2'd3:    mapped_c[2*k+2] = bus.in_data[k];
                default: mapped_c[2*k+1] = bus.in_data[k];
            endcase
        end
    end

    // Next state: collect beats, drop duplicates, hold result until taken
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mask_d      = mask_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        err_dup_d   = 1'b0;

        unique case (state_q)
            S_COLLECT: begin
                if (bus.abort) begin
                    acc_d  = '0;
                    mask_d = '0;
                end else if (accept_c) begin
                    if ((mask_q & sel_bit_c) != 4'b0000) begin
                        err_dup_d = 1'b1;
                    end else begin
                        acc_d  = acc_q ^ mapped_c;
                        mask_d = mask_q | sel_bit_c;
                        if (mask_d == 4'b1111) begin
                            state_d     = S_HOLD;
                            out_data_d  = acc_d;
                            out_valid_d = 1'b1;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d     = S_COLLECT;
                    acc_d       = '0;
                    mask_d      = '0;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_COLLECT;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_COLLECT;
            acc_q       <= '0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_dup_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            err_dup_q   <= err_dup_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.beat_mask = mask_q;
    assign bus.err_dup   = err_dup_q;
endmodule
